video_line_packer_writer: RTL and testbench
===========================================

Name: video_line_packer_writer

Overview:
- Streaming-to-memory stage that drives the second port (s2) of the 2048x32 dual-port on-chip pixel memory.
- Accepts an 8-bit pixel stream with valid/ready and start/end-of-line markers.
- Packs four pixels per 32-bit word and writes each line into one of two ping-pong banks, each half of the memory.
- The Nios side reads completed banks through port s1 and hands each bank back with a release pulse.

Parameters:
- PIXEL_W, 8, pixel width; the design supports only 8.
- ADDR_W, 11, memory word address width; the MSB selects the bank.
- BANK_WORDS, 1024, words per bank; equals 2^(ADDR_W-1).

Ports:
- clk  in  1  single clock, shared with the memory's clk2.
- reset  in  1  synchronous, active-high.
- pix_data  in  8  pixel.
- pix_valid  in  1  pixel present.
- pix_sop  in  1  first pixel of a line; qualified by pix_valid.
- pix_eop  in  1  last pixel of a line; qualified by pix_valid. sop and eop on the same pixel is legal.
- pix_ready  out  1  pixel is accepted when pix_valid & pix_ready.
- bank_release  in  2  one-cycle pulse per bank; host has finished reading that bank.
- mem_address  out  11  {bank, word_index}.
- mem_chipselect  out  1  asserted with mem_write.
- mem_write  out  1  write strobe, one cycle per word.
- mem_writedata  out  32  packed pixels.
- mem_byteenable  out  4  valid bytes.
- mem_clken  out  1  constant 1 when out of reset.
- line_done  out  1  one-cycle pulse when a line is complete.
- line_bank  out  1  bank of the completed line; held until the next line_done.
- line_words  out  11  words written for that line (0..1024); held until the next line_done.
- overflow  out  1  sticky; cleared only by reset.
- sop_error  out  1  sticky; cleared only by reset.

Behaviour:
- Reset values: all outputs 0, except pix_ready=1 and mem_clken=1 from the first cycle after reset. Both banks free, current bank 0, state IDLE.
- Reset mid-line: the partial word is discarded and no write is issued.
- Packing: little-endian. Pixel n of a word goes to bits [8n+7:8n].
- Write latency: outputs are registered. The write for a word appears on the cycle after the pixel that completes it.
  - Full word: byteenable 4'b1111.
  - Partial word at eop with k pixels: byteenable = (1<<k)-1.
- Addressing: word_index starts at 0 for each line and increments after every write; no wrap.
- State machine:
  - IDLE: pix_ready=1. Pixels without sop are dropped and not counted. An accepted sop pixel goes to FILL, or to DONE if eop is also set.
  - FILL: pix_ready=1; pixels are packed.
    - Accepted sop: restart the line at word 0 of the same bank, discard the partial word, set sop_error.
    - Accepted eop: go to DONE.
    - After 1024 words are written, further pixels are accepted but dropped and overflow is set. The eop is still honoured.
  - DONE (1 cycle): pix_ready=0.
    - Emit the final partial-word write if k>0.
    - Pulse line_done, update line_bank and line_words (the final partial word counts).
    - Mark the current bank full and toggle the bank.
    - Next state: IDLE if the new bank is free, else WAIT_BANK.
  - WAIT_BANK: pix_ready=0. Go to IDLE on the cycle after the current bank's full flag clears.
- bank_release:
  - A release for a bank that is not full is ignored.
  - A release arriving in the same cycle as DONE marks the bank full: the release applies to the bank's previous state, then the full set wins for the bank being completed.
  - Both bits may pulse together.
- The memory has no waitrequest, so at most one write is issued per cycle.

Decomposition:
- Shared package video_switch_pkg:
  - State enum: IDLE, FILL, DONE, WAIT_BANK.
  - Constants PIX_PER_WORD=4 and BANK_WORDS.
  - Function be_mask(k).
- One sub-module, video_pixel_packer: the 4:1 byte-lane packer with pixel count and flush. It outputs word, byteenable and word_valid.
- The top holds the FSM, bank flags and addressing.

Test Plan:
- Reset, then a line of 8 pixels 0x01..0x08 into bank 0 -> writes addr 0 = 0x04030201, addr 1 = 0x08070605, both be=4'hF. line_done with line_bank=0, line_words=2.
- Line of 6 pixels 0xA0..0xA5 -> addr 0 = 0xA3A2A1A0, then addr 1 data[15:0]=0xA5A4 with be=4'h3, line_words=2. Single pixel with sop and eop both set -> be=4'h1, line_words=1.
- Two lines with no release -> second line written at addr 1024+, then pix_ready=0 in WAIT_BANK. bank_release=2'b01 -> pix_ready=1 the cycle after the flag clears; the third line goes to bank 0.
- Line of 4100 pixels -> exactly 1024 writes (last at addr 1023), overflow=1, line_words=1024, and the eop still completes the line.
- Stray pixels before any sop -> no writes. A sop at pixel 3 of a line -> sop_error=1 and the line restarts at addr 0.
- reset asserted in FILL after 2 pixels -> no write; outputs at reset values; the next line starts in bank 0 at addr 0.

Source files
------------

// File: rtl/video_switch_pkg.sv
// Shared types and constants for the video line packer / bank writer.
package video_switch_pkg;

    typedef enum logic [1:0] {IDLE, FILL, DONE, WAIT_BANK} state_t;

    localparam int PIX_PER_WORD = 4;
    localparam int BANK_WORDS   = 1024;

    // Byte-enable mask for a partial word holding k pixels.
    function automatic logic [3:0] be_mask(input logic [2:0] k);
        logic [4:0] m;
        m = (5'd1 << k) - 5'd1;
        return m[3:0];
    endfunction

endpackage

// File: rtl/video_pixel_packer.sv
// Packs four pixels little-endian into one 32-bit word; a flush emits any partial word.
module video_pixel_packer
    import video_switch_pkg::*;
#(
    parameter int PIXEL_W = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              pix_en,
    input  logic                              pix_start,
    input  logic [PIXEL_W-1:0]                pix,
    input  logic                              flush,
    output logic [PIX_PER_WORD*PIXEL_W-1:0]   word,
    output logic [3:0]                        byteenable,
    output logic                              word_valid,
    output logic [1:0]                        fill_count
);

    localparam int WORD_W = PIX_PER_WORD * PIXEL_W;

    logic [WORD_W-1:0] pix_buf;
    logic [WORD_W-1:0] buf_next;
    logic [1:0]        lane;

    // A start pixel discards any partial word and lands in lane 0.
    always_comb begin
        lane     = pix_start ? 2'd0 : fill_count;
        buf_next = pix_start ? '0 : pix_buf;
        buf_next[lane*PIXEL_W +: PIXEL_W] = pix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_buf    <= '0;
            fill_count <= 2'd0;
            word       <= '0;
            byteenable <= 4'h0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (pix_en) begin
                if (lane == 2'(PIX_PER_WORD - 1)) begin
                    word       <= buf_next;
                    byteenable <= 4'hF;
                    word_valid <= 1'b1;
                    pix_buf    <= '0;
                    fill_count <= 2'd0;
                end else begin
                    pix_buf    <= buf_next;
                    fill_count <= lane + 2'd1;
                end
            end else if (flush) begin
                if (fill_count != 2'd0) begin
                    word       <= pix_buf;
                    byteenable <= be_mask({1'b0, fill_count});
                    word_valid <= 1'b1;
                end
                pix_buf    <= '0;
                fill_count <= 2'd0;
            end
        end
    end

endmodule

// File: rtl/video_line_packer_writer.sv
// Writes pixel lines into ping-pong banks of the s2 memory port; the host frees banks via bank_release.
module video_line_packer_writer
    import video_switch_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int ADDR_W  = 11,
    parameter int LINE_WORDS = BANK_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PIXEL_W-1:0]   pix_data,
    input  logic                 pix_valid,
    input  logic                 pix_sop,
    input  logic                 pix_eop,
    output logic                 pix_ready,
    input  logic [1:0]           bank_release,
    output logic [ADDR_W-1:0]    mem_address,
    output logic                 mem_chipselect,
    output logic                 mem_write,
    output logic [31:0]          mem_writedata,
    output logic [3:0]           mem_byteenable,
    output logic                 mem_clken,
    output logic                 line_done,
    output logic                 line_bank,
    output logic [ADDR_W-1:0]    line_words,
    output logic                 overflow,
    output logic                 sop_error
);

    localparam logic [ADDR_W-1:0] FULL_COUNT = ADDR_W'(LINE_WORDS);

    state_t            state;
    logic              bank;
    logic [1:0]        bank_full;
    logic [1:0]        released_full;
    logic [ADDR_W-1:0] word_index;
    logic              accept;
    logic              pk_en;
    logic              pk_start;
    logic              pk_flush;
    logic              word_complete;
    logic [1:0]        fill_count;
    logic              word_valid;

    assign accept         = pix_valid & pix_ready;
    assign released_full  = bank_full & ~bank_release;
    assign word_complete  = pk_en & ~pk_start & (fill_count == 2'(PIX_PER_WORD - 1));
    assign mem_write      = word_valid;
    assign mem_chipselect = word_valid;

    // Pixels reach the packer only inside a line and only while the bank has room.
    always_comb begin
        pk_en    = 1'b0;
        pk_start = 1'b0;
        pk_flush = 1'b0;
        case (state)
            IDLE: begin
                if (accept && pix_sop) begin
                    pk_en    = 1'b1;
                    pk_start = 1'b1;
                end
            end
            FILL: begin
                if (accept) begin
                    if (pix_sop) begin
                        pk_en    = 1'b1;
                        pk_start = 1'b1;
                    end else if (word_index != FULL_COUNT) begin
                        pk_en = 1'b1;
                    end
                end
            end
            DONE:    pk_flush = 1'b1;
            default: ;
        endcase
    end

    video_pixel_packer #(
        .PIXEL_W (PIXEL_W)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pk_en),
        .pix_start  (pk_start),
        .pix        (pix_data),
        .flush      (pk_flush),
        .word       (mem_writedata),
        .byteenable (mem_byteenable),
        .word_valid (word_valid),
        .fill_count (fill_count)
    );

    // Release clears first; a bank completing this cycle is then marked full.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bank        <= 1'b0;
            bank_full   <= 2'b00;
            word_index  <= '0;
            mem_address <= '0;
            pix_ready   <= 1'b1;
            mem_clken   <= 1'b1;
            line_done   <= 1'b0;
            line_bank   <= 1'b0;
            line_words  <= '0;
            overflow    <= 1'b0;
            sop_error   <= 1'b0;
        end else begin
            line_done <= 1'b0;
            bank_full <= released_full;
            case (state)
                IDLE: begin
                    if (accept && pix_sop) begin
                        word_index <= '0;
                        if (pix_eop) begin
                            state     <= DONE;
                            pix_ready <= 1'b0;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (pix_sop) begin
                            sop_error  <= 1'b1;
                            word_index <= '0;
                        end else if (word_index == FULL_COUNT) begin
                            overflow <= 1'b1;
                        end else if (word_complete) begin
                            mem_address <= {bank, word_index[ADDR_W-2:0]};
                            word_index  <= word_index + 1'b1;
                        end
                        if (pix_eop) begin
                            state     <= DONE;
                            pix_ready <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (fill_count != 2'd0) begin
                        mem_address <= {bank, word_index[ADDR_W-2:0]};
                    end
                    line_done       <= 1'b1;
                    line_bank       <= bank;
                    line_words      <= word_index + ADDR_W'(fill_count != 2'd0);
                    bank_full[bank] <= 1'b1;
                    bank            <= ~bank;
                    if (released_full[~bank]) begin
                        state <= WAIT_BANK;
                    end else begin
                        state     <= IDLE;
                        pix_ready <= 1'b1;
                    end
                end
                WAIT_BANK: begin
                    if (!bank_full[bank]) begin
                        state     <= IDLE;
                        pix_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_line_packer_writer.sv
// Scoreboard bench: a queue-based line model predicts memory writes and line completions.
module tb_video_line_packer_writer;

    typedef struct {
        logic [10:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        logic        bank;
        logic [10:0] words;
    } ln_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pix_data = 8'h00;
    logic        pix_valid = 1'b0;
    logic        pix_sop = 1'b0;
    logic        pix_eop = 1'b0;
    logic        pix_ready;
    logic [1:0]  bank_release = 2'b00;
    logic [10:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_clken;
    logic        line_done;
    logic        line_bank;
    logic [10:0] line_words;
    logic        overflow;
    logic        sop_error;

    wr_t          expWr[$];
    ln_t          expLn[$];
    int           checks = 0;
    int           errors = 0;
    bit           autoRelease = 1'b1;

    bit           mInLine;
    logic [7:0]   mCur[$];
    bit           mBank;
    bit           mOverflow;
    bit           mSopErr;

    video_line_packer_writer dut (
        .clk            (clk),
        .reset          (reset),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_sop        (pix_sop),
        .pix_eop        (pix_eop),
        .pix_ready      (pix_ready),
        .bank_release   (bank_release),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .line_done      (line_done),
        .line_bank      (line_bank),
        .line_words     (line_words),
        .overflow       (overflow),
        .sop_error      (sop_error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] byteMask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Model: a line is the list of kept pixels; every 4th pixel forms a word, eop flushes the rest.
    task automatic pushWrite(input int idx, input int first, input int k);
        wr_t w;
        w.data = '0;
        for (int i = 0; i < k; i++) w.data[8*i +: 8] = mCur[first + i];
        w.be   = 4'((1 << k) - 1);
        w.addr = {mBank, 10'(idx)};
        expWr.push_back(w);
    endtask

    task automatic modelPixel(input logic [7:0] d, input bit s, input bit e);
        int  rem;
        ln_t ln;
        if (s) begin
            if (mInLine) mSopErr = 1'b1;
            mCur.delete();
            mInLine = 1'b1;
        end else if (!mInLine) begin
            return;
        end
        if (mCur.size() < 4096) begin
            mCur.push_back(d);
            if (mCur.size() % 4 == 0) pushWrite(mCur.size() / 4 - 1, mCur.size() - 4, 4);
        end else begin
            mOverflow = 1'b1;
        end
        if (e) begin
            rem = mCur.size() % 4;
            if (rem != 0) pushWrite(mCur.size() / 4, mCur.size() - rem, rem);
            ln.bank  = mBank;
            ln.words = 11'((mCur.size() + 3) / 4);
            expLn.push_back(ln);
            mBank   = ~mBank;
            mInLine = 1'b0;
            mCur.delete();
        end
    endtask

    task automatic driveRelease();
        if (autoRelease && $urandom_range(0, 3) == 0) bank_release = 2'($urandom_range(1, 3));
        else bank_release = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            driveRelease();
            pix_valid = 1'b0;
        end
    endtask

    // Offers one pixel until the DUT takes it; the model sees it only on acceptance.
    task automatic applyStimulus(input logic [7:0] d, input bit s, input bit e);
        bit done = 1'b0;
        bit rdy;
        int waitN = 0;
        while (!done) begin
            @(negedge clk);
            driveRelease();
            pix_valid = 1'b1;
            pix_data  = d;
            pix_sop   = s;
            pix_eop   = e;
            rdy       = pix_ready;
            @(posedge clk);
            if (rdy) begin
                modelPixel(d, s, e);
                done = 1'b1;
            end else if (++waitN > 400) begin
                checks++;
                errors++;
                $display("[TB] FAIL ready_timeout: pix_ready stayed 0, expected 1 within 400 cycles");
                done = 1'b1;
            end
            #1 pix_valid = 1'b0;
        end
    endtask

    task automatic sendLine(input int len, input int base, input int restartAt, input bit randData, input bit gaps);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = randData ? 8'($urandom_range(0, 255)) : 8'(base + i);
            applyStimulus(d, (i == 0) || (i == restartAt), i == len - 1);
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset        = 1'b1;
        pix_valid    = 1'b0;
        bank_release = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expWr.delete();
        expLn.delete();
        mCur.delete();
        mInLine   = 1'b0;
        mBank     = 1'b0;
        mOverflow = 1'b0;
        mSopErr   = 1'b0;
        checkOutput("rst_pix_ready", pix_ready, 1);
        checkOutput("rst_mem_clken", mem_clken, 1);
        checkOutput("rst_mem_write", mem_write, 0);
        checkOutput("rst_mem_cs", mem_chipselect, 0);
        checkOutput("rst_mem_address", mem_address, 0);
        checkOutput("rst_line_done", line_done, 0);
        checkOutput("rst_line_words", line_words, 0);
        checkOutput("rst_line_bank", line_bank, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_sop_error", sop_error, 0);
    endtask

    // Monitor: every write and every line_done must match the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_write) begin
                if (expWr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: addr=0x%0h data=0x%0h, expected no write", mem_address, mem_writedata);
                end else begin
                    wr_t w;
                    w = expWr.pop_front();
                    checkOutput("wr_addr", mem_address, w.addr);
                    checkOutput("wr_be", mem_byteenable, w.be);
                    checkOutput("wr_data", mem_writedata & byteMask(w.be), w.data);
                    checkOutput("wr_cs", mem_chipselect, 1);
                end
            end
            if (line_done) begin
                if (expLn.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_line_done: bank=%0d words=%0d, expected none", line_bank, line_words);
                end else begin
                    ln_t l;
                    l = expLn.pop_front();
                    checkOutput("line_bank", line_bank, l.bank);
                    checkOutput("line_words", line_words, l.words);
                end
            end
        end
    end

    initial begin
        int len;
        int restartAt;

        doReset();

        sendLine(8, 8'h01, -1, 1'b0, 1'b0);
        sendLine(6, 8'hA0, -1, 1'b0, 1'b0);
        applyStimulus(8'h5A, 1'b1, 1'b1);
        idle(4);

        applyStimulus(8'h11, 1'b0, 1'b0);
        applyStimulus(8'h12, 1'b0, 1'b1);
        applyStimulus(8'h13, 1'b0, 1'b0);
        sendLine(9, 8'h30, 2, 1'b0, 1'b0);
        idle(4);
        checkOutput("sop_error_restart", sop_error, mSopErr);

        sendLine(4100, 0, -1, 1'b1, 1'b0);
        idle(4);
        checkOutput("overflow_long_line", overflow, mOverflow);

        applyStimulus(8'h77, 1'b1, 1'b0);
        applyStimulus(8'h78, 1'b0, 1'b0);
        doReset();
        sendLine(5, 8'hC0, -1, 1'b0, 1'b0);
        idle(4);

        doReset();
        autoRelease = 1'b0;
        sendLine(3, 8'h40, -1, 1'b0, 1'b0);
        sendLine(5, 8'h50, -1, 1'b0, 1'b0);
        idle(4);
        checkOutput("wait_bank_ready", pix_ready, 0);
        @(negedge clk);
        bank_release = 2'b01;
        @(negedge clk);
        bank_release = 2'b00;
        checkOutput("release_ready_early", pix_ready, 0);
        @(negedge clk);
        checkOutput("release_ready", pix_ready, 1);
        sendLine(4, 8'h60, -1, 1'b0, 1'b0);
        idle(4);
        autoRelease = 1'b1;

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) applyStimulus(8'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)));
            len       = $urandom_range(1, 40);
            restartAt = (len > 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, len - 1) : -1;
            sendLine(len, 0, restartAt, 1'b1, 1'b1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(12);
        checkOutput("final_sop_error", sop_error, mSopErr);
        checkOutput("final_overflow", overflow, mOverflow);
        checkOutput("pending_writes", expWr.size(), 0);
        checkOutput("pending_lines", expLn.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
